// File: rtl/rx_word_streamer.sv
// rx_word_streamer: pops one receive-buffer batch and streams its words over valid/ready,
// tagging each batch with the line errors seen since the previous capture.
module rx_word_streamer #(
  parameter int WORD_SIZE   = 7,
  parameter int NO_OF_WORDS = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             buffer_full,
  input  logic [NO_OF_WORDS*WORD_SIZE-1:0] data_parallel_in,
  input  logic                             parity_error,
  input  logic                             stop_bit_error,
  output logic                             data_parallel_rd_enable,
  output logic [WORD_SIZE-1:0]             m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_last,
  output logic                             m_error,
  output logic [15:0]                      word_count
);
  localparam int IW = NO_OF_WORDS > 1 ? $clog2(NO_OF_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NO_OF_WORDS - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  logic [0:0]                       state_q, state_d;
  logic [NO_OF_WORDS*WORD_SIZE-1:0] snap_q, snap_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic                             rd_q, rd_d;
  logic                             err_q, err_d;
  logic                             acc_q, acc_d;
  logic [15:0]                      cnt_q, cnt_d;
  logic                             capture, hs, line_err;
  assign capture  = state_q == IDLE && buffer_full;
  assign hs       = m_valid && m_ready;
  assign line_err = parity_error | stop_bit_error;
  assign m_valid  = state_q == STREAM;
  assign m_last   = m_valid && idx_q == LAST_IDX;
  assign m_data   = snap_q[32'(idx_q)*WORD_SIZE +: WORD_SIZE];
  assign m_error  = err_q;
  assign data_parallel_rd_enable = rd_q;
  assign word_count = cnt_q;
  // idx returns to 0 after the last word so m_data never indexes past the snapshot
  always_comb begin
    state_d = capture ? STREAM : (hs && m_last) ? IDLE : state_q;
    snap_d  = capture ? data_parallel_in : snap_q;
    idx_d   = (capture || (hs && m_last)) ? '0 : hs ? idx_q + 1'b1 : idx_q;
    rd_d    = capture;
    err_d   = capture ? (acc_q | line_err) : err_q;
    acc_d   = capture ? 1'b0 : (acc_q | line_err);
    cnt_d   = hs ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/rx_word_streamer.md
# rx_word_streamer

Downstream consumer of the UART receive path. Watches the receive buffer's full flag and pops one batch of `NO_OF_WORDS` words through the parallel read interface. It then streams those words one per handshake on a valid/ready output port, tagging each batch with an accumulated line-error flag and maintaining a running word count. It sits between the receive wrapper's buffer outputs and any byte-oriented consumer (command parser, FIFO, bus bridge).

## Interface
- `WORD_SIZE`, 7, data bits per word; must match the receiver's `NO_OF_DATA_BITS` (6, 7 or 8).
- `NO_OF_WORDS`, 2, words per buffer batch; must match the receiver's `NO_OF_WORS_IN_BUFFER`; ≥1.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `buffer_full`  in  1  receive buffer holds a complete batch.
- `data_parallel_in`  in  `NO_OF_WORDS*WORD_SIZE`  batch contents; word k occupies bits `[k*WORD_SIZE +: WORD_SIZE]`; word 0 is the earliest received.
- `parity_error`  in  1  receiver parity error indication (level or pulse).
- `stop_bit_error`  in  1  receiver stop-bit error indication (level or pulse).
- `data_parallel_rd_enable`  out  1  one-cycle pop strobe to the receive buffer.
- `m_data`  out  `WORD_SIZE`  current output word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_last`  out  1  current word is the final word of its batch.
- `m_error`  out  1  the batch containing the current word saw a line error.
- `word_count`  out  16  number of words accepted on the output port, modulo 2^16.

## Operation
- FSM states are IDLE and STREAM.
- IDLE:
  - `m_valid`=0.
  - When `buffer_full`=1, the next edge loads the snapshot register from `data_parallel_in`, sets `data_parallel_rd_enable`=1 for that one cycle, clears `idx` to 0, and enters STREAM.
- STREAM:
  - `m_valid`=1 and `m_data` = snapshot word `idx`.
  - `m_last` = (`idx`==`NO_OF_WORDS`-1).
  - On `m_valid && m_ready`, `idx` increments and `word_count` increments, wrapping 0xFFFF→0x0000.
  - When the handshake occurs with `m_last`=1, the FSM returns to IDLE.
  - `buffer_full` is ignored while in STREAM.
- Error accumulator `err_acc`:
  - Set in any cycle where `parity_error | stop_bit_error` is high.
  - On the capture edge, `m_error` is loaded with `err_acc | parity_error | stop_bit_error`, and `err_acc` clears.
  - An error arriving during STREAM is charged to the next batch.
- `m_data`, `m_error` and `m_last` are held stable while `m_valid`=1 and `m_ready`=0.
- `m_ready` may be high or low in any state. It has no effect in IDLE.
- Upstream contract: the receive buffer drops `buffer_full` in the cycle after it samples `data_parallel_rd_enable`. Under this contract a batch is never popped twice, even with `NO_OF_WORDS`=1 and `m_ready` held high.

## Timing
- Reset values: `data_parallel_rd_enable`=0, `m_valid`=0, `m_last`=0, `m_error`=0, `m_data`=0, `word_count`=0, `err_acc`=0, state IDLE.
- Latency: `buffer_full` high in IDLE at cycle T gives `data_parallel_rd_enable`=1 and `m_valid`=1 at T+1. Both are registered.
- Throughput: one word per cycle while `m_ready`=1. A batch of N words costs N cycles, plus 1 IDLE cycle before the next capture.
- `data_parallel_rd_enable` is never high for two consecutive cycles, and is never high outside the capture cycle.
- Reset mid-STREAM: the next edge returns to IDLE with all outputs at reset values. The popped batch is discarded, and `word_count` and `err_acc` are cleared.
- Reset and `buffer_full` high in the same cycle: reset wins; no pop.
- Backpressure has no upper bound. The block waits in STREAM indefinitely, and the receive buffer is responsible for its own overrun handling.

## Test plan
- Clean batch: `WORD_SIZE`=7, `NO_OF_WORDS`=2, `data_parallel_in`={7'h55,7'h2A}, `buffer_full` pulsed, `m_ready`=1 -> one `data_parallel_rd_enable` pulse. Outputs are 7'h2A (`m_last`=0) then 7'h55 (`m_last`=1), `m_error`=0, and `word_count`=2.
- Backpressure: same batch with `m_ready` low for 5 cycles -> `m_valid`=1 and `m_data`=7'h2A held stable for 5 cycles. The word is accepted on the first `m_ready` cycle, and there is no second pop.
- Error tagging: a 1-cycle `parity_error` pulse while IDLE, then a batch -> both words carry `m_error`=1. A `stop_bit_error` during that STREAM leaves the current batch's `m_error` unchanged and sets `m_error`=1 on the following batch only.
- Back-to-back: `NO_OF_WORDS`=1, `m_ready`=1, `buffer_full` re-asserted immediately after the buffer clears -> exactly one pop per batch and no duplicated word. `word_count` matches the number of batches.
- Reset mid-stream: assert `reset`=0 after the first word is accepted -> next cycle `m_valid`=0, `word_count`=0 and the FSM is in IDLE. A later batch streams normally.
- Wrap: preload 65,535 accepted words, then send 2 more -> `word_count` reads 0xFFFF, then 0x0000, then 0x0001.
